// File: rtl/jedro_1_alu_arb.sv
// jedro_1_alu_arb: round-robin arbiter sharing one jedro_1_alu between the
// execute stage (port 0) and the address/aux unit (port 1). A granted request
// is latched, issued to the ALU with a one-cycle pulse, and its result (or a
// timeout error) is returned to the owner as a one-cycle res_valid pulse.
module jedro_1_alu_arb #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] req0_op_i,
    input  logic [DATA_WIDTH-1:0]   req0_opa_i,
    input  logic [DATA_WIDTH-1:0]   req0_opb_i,
    output logic                    req0_res_valid_o,

    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] req1_op_i,
    input  logic [DATA_WIDTH-1:0]   req1_opa_i,
    input  logic [DATA_WIDTH-1:0]   req1_opb_i,
    output logic                    req1_res_valid_o,

    output logic [DATA_WIDTH-1:0]   res_o,
    output logic                    res_err_o,

    output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
    output logic [DATA_WIDTH-1:0]   alu_opa_o,
    output logic [DATA_WIDTH-1:0]   alu_opb_o,
    output logic                    alu_op_ready_o,
    input  logic [DATA_WIDTH-1:0]   alu_res_i,
    input  logic                    alu_res_ready_i
);

    // The counter only has to reach TIMEOUT-1 before the error response fires.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;  // port served most recently
    logic             owner;       // port that owns the in-flight operation
    logic             grant;       // port selected this cycle while IDLE
    logic [CNT_W-1:0] cnt;

    // Round-robin selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign req0_ready_o = (state == IDLE) && !grant && req0_valid_i;
    assign req1_ready_o = (state == IDLE) &&  grant && req1_valid_i;

    // Arbitration FSM: accept, issue, wait for the ALU, then return result or timeout error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            cnt              <= '0;
            alu_op_sel_o     <= '0;
            alu_opa_o        <= '0;
            alu_opb_o        <= '0;
            alu_op_ready_o   <= 1'b0;
            res_o            <= '0;
            res_err_o        <= 1'b0;
            req0_res_valid_o <= 1'b0;
            req1_res_valid_o <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            // Pulse outputs default low and are raised only on the cycle they apply.
            alu_op_ready_o   <= 1'b0;
            res_err_o        <= 1'b0;
            req0_res_valid_o <= 1'b0;
            req1_res_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0_ready_o || req1_ready_o) begin
                        alu_op_sel_o   <= grant ? req1_op_i  : req0_op_i;
                        alu_opa_o      <= grant ? req1_opa_i : req0_opa_i;
                        alu_opb_o      <= grant ? req1_opb_i : req0_opb_i;
                        last_grant     <= grant;
                        owner          <= grant;
                        alu_op_ready_o <= 1'b1;  // high during the ISSUE cycle only
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A result arriving on the last allowed cycle still beats the timeout.
                    if (alu_res_ready_i) begin
                        res_o            <= alu_res_i;
                        res_err_o        <= 1'b0;
                        req0_res_valid_o <= !owner;
                        req1_res_valid_o <= owner;
                        state            <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        res_o            <= '0;
                        res_err_o        <= 1'b1;
                        req0_res_valid_o <= !owner;
                        req1_res_valid_o <= owner;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_alu_arb.sv
// tb_jedro_1_alu_arb: scoreboard bench for the ALU arbiter with a small ALU stub
// whose result-ready delay is programmable (stub_delay WAIT cycles after issue).
module tb_jedro_1_alu_arb;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int TO = 15;

    localparam logic [OW-1:0] OP_ADD = 4'd0;
    localparam logic [OW-1:0] OP_SUB = 4'd1;
    localparam logic [OW-1:0] OP_XOR = 4'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_res_valid;
    logic [OW-1:0] req0_op;
    logic [DW-1:0] req0_opa, req0_opb;
    logic          req1_valid, req1_ready, req1_res_valid;
    logic [OW-1:0] req1_op;
    logic [DW-1:0] req1_opa, req1_opb;
    logic [DW-1:0] res;
    logic          res_err;
    logic [OW-1:0] alu_op_sel;
    logic [DW-1:0] alu_opa, alu_opb, alu_res;
    logic          alu_op_ready, alu_res_ready;

    jedro_1_alu_arb #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
        .req0_opa_i(req0_opa), .req0_opb_i(req0_opb), .req0_res_valid_o(req0_res_valid),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
        .req1_opa_i(req1_opa), .req1_opb_i(req1_opb), .req1_res_valid_o(req1_res_valid),
        .res_o(res), .res_err_o(res_err),
        .alu_op_sel_o(alu_op_sel), .alu_opa_o(alu_opa), .alu_opb_o(alu_opb),
        .alu_op_ready_o(alu_op_ready), .alu_res_i(alu_res), .alu_res_ready_i(alu_res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] res;
        logic          err;
        int            hs_cyc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   resp_port[$];
    int   resp_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   stub_delay = 1;
    int   since    = 0;
    bit   armed    = 1'b0;
    exp_t mon_e;
    int   mon_port;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    // ALU stub: combinational result, res_ready raised stub_delay cycles after the issue pulse.
    assign alu_res = alu_fn(alu_op_sel, alu_opa, alu_opb);

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            armed = 1'b0;
            alu_res_ready = 1'b0;
        end else if (alu_op_ready) begin
            armed = 1'b1;
            since = 0;
            alu_res_ready = 1'b0;
        end else if (armed) begin
            since++;
            if (since == stub_delay) begin
                alu_res_ready = 1'b1;
                armed = 1'b0;
            end else begin
                alu_res_ready = 1'b0;
            end
        end else begin
            alu_res_ready = 1'b0;
        end
    end

    // Response monitor: every res_valid pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && (req0_res_valid || req1_res_valid)) begin
            mon_port = req1_res_valid ? 1 : 0;
            if (req0_res_valid && req1_res_valid) check("dual_res_valid", 1, 0);
            resp_port.push_back(mon_port);
            resp_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_port", mon_port, mon_e.port);
                check("res_o", res, mon_e.res);
                check("res_err_o", res_err, mon_e.err);
                check("latency", cyc - mon_e.hs_cyc, mon_e.lat);
            end
        end
    end

    // Present one request at the next negedge, wait (bounded) for ready, record the expectation.
    task automatic drive_txn(input int port, input logic [OW-1:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input bit keep, output int waited);
        exp_t e;
        bit   rdy;
        waited = 0;
        @(negedge clk);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_opa = a; req0_opb = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_opa = a; req1_opb = b;
        end
        #1;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && waited < 100) begin
            @(negedge clk); #1;
            waited++;
            rdy = (port == 0) ? req0_ready : req1_ready;
        end
        if (!rdy) begin
            check($sformatf("ready_timeout_p%0d", port), 0, 1);
        end else begin
            e.port   = port;
            e.err    = (stub_delay > TO);
            e.res    = e.err ? '0 : alu_fn(op, a, b);
            e.hs_cyc = cyc;
            e.lat    = e.err ? TO + 2 : stub_delay + 2;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (!keep) begin
            if (port == 0) req0_valid = 1'b0;
            else           req1_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w0, w1, nresp;
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_opa = '0; req0_opb = '0;
        req1_valid = 1'b0; req1_op = '0; req1_opa = '0; req1_opb = '0;
        alu_res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_op_ready", alu_op_ready, 0);
        check("rst_res", res, 0);
        check("rst_err", res_err, 0);
        check("rst_res_valid", {req0_res_valid, req1_res_valid}, 0);
        check("rst_alu_opa", alu_opa, 0);
        check("rst_alu_op_sel", alu_op_sel, 0);

        // 1: single ADD 5+7 on port 0, latency T/T+1/T+3
        stub_delay = 1;
        drive_txn(0, OP_ADD, 32'd5, 32'd7, 1'b0, w);
        check("t1_ready_immediate", w, 0);
        @(negedge clk); #1;
        check("t1_op_ready_issue", alu_op_ready, 1);
        check("t1_alu_op_sel", alu_op_sel, OP_ADD);
        check("t1_alu_opa", alu_opa, 5);
        check("t1_alu_opb", alu_opb, 7);
        @(negedge clk); #1;
        check("t1_op_ready_wait", alu_op_ready, 0);
        check("t1_res_valid_early", req0_res_valid, 0);
        @(negedge clk); #1;
        check("t1_res_valid", req0_res_valid, 1);
        check("t1_res", res, 12);
        check("t1_err", res_err, 0);
        check("t1_res_valid_p1", req1_res_valid, 0);
        @(negedge clk); #1;
        check("t1_res_valid_pulse", req0_res_valid, 0);
        check("t1_res_hold", res, 12);

        // 6: wrap-around add, operand latches hold while requester inputs change
        stub_delay = 3;
        drive_txn(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, w);
        req0_opa = 32'h1234_5678;
        req0_opb = 32'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("t6_alu_opa_hold", alu_opa, 32'hFFFF_FFFF);
            check("t6_alu_opb_hold", alu_opb, 1);
        end
        drain();
        check("t6_res_wrap", res, 0);

        // 3: ALU never answers on port 1 -> timeout error, then FSM idle again
        stub_delay = 1000;
        drive_txn(1, OP_ADD, 32'd3, 32'd4, 1'b0, w);
        drain();
        stub_delay = 1;
        drive_txn(0, OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, w);
        check("t3_idle_after_timeout", w, 0);
        drain();

        // 4: res_ready on the TIMEOUT-th WAIT cycle wins over the timeout
        stub_delay = TO;
        drive_txn(1, OP_SUB, 32'd100, 32'd58, 1'b0, w);
        drain();

        // 5: reset during WAIT drops the transaction; port 0 wins the next tie
        stub_delay = 1000;
        drive_txn(0, OP_ADD, 32'd1, 32'd2, 1'b0, w);
        repeat (4) @(negedge clk);
        nresp = resp_port.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (20) @(negedge clk);
        check("t5_no_resp_after_reset", resp_port.size(), nresp);
        stub_delay = 1;
        fork
            drive_txn(0, OP_ADD, 32'd10, 32'd20, 1'b0, w0);
            drive_txn(1, OP_SUB, 32'd50, 32'd8, 1'b0, w1);
        join
        drain();
        check("t5_tie_p0_wait", w0, 0);
        check("t5_tie_p1_wait", w1, 3);

        // 2: both ports continuously valid after reset -> grants alternate 0,1,0,1,...
        do_reset();
        resp_port.delete();
        resp_cyc.delete();
        fork
            for (int k = 0; k < 3; k++) drive_txn(0, OP_SUB, 32'd100 + k, k, k < 2, w0);
            for (int k = 0; k < 3; k++) drive_txn(1, OP_XOR, 32'hF0 + k, 32'h0F, k < 2, w1);
        join
        drain();
        check("t2_num_resp", resp_port.size(), 6);
        for (int i = 0; i < resp_port.size(); i++) begin
            check($sformatf("t2_port_%0d", i), resp_port[i], i % 2);
            if (i > 0) check($sformatf("t2_spacing_%0d", i), resp_cyc[i] - resp_cyc[i-1], 3);
        end

        check("sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
